ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
- Registered, stall-aware successor to the combinational RV32I control decoder. It sits at the ID/EX boundary.
- Decodes opcode_in, captures the control bundle into an ID/EX register, and owns a small FSM. The FSM holds the pipeline during memory wait states (mem_ack handshake with timeout) and raises traps for ECALL/EBREAK.
- Decode mapping (R/I/load/store/branch/jump/U/system groups to control_types encodings) is unchanged from the existing single-cycle control unit.

Parameters:
- TIMEOUT, 15, max MEM_WAIT cycles without mem_ack_i before fault; legal range 1..255.
- MEM_WAIT_EN, 1, 1 means loads/stores enter MEM_WAIT; 0 means memory ops are single-cycle and mem_ack_i is ignored.
- SYS_TRAP_EN, 1, 1 means ECALL/EBREAK enter TRAP; 0 means they decode as NOP.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr_valid_i  in  1  opcode_in holds a valid instruction
- opcode_in  in  opcode_out_t  decoded instruction
- flush_i  in  1  kill the instruction being captured (branch/jump redirect)
- mem_ack_i  in  1  data memory completed current access
- trap_ack_i  in  1  trap handler accepted trap
- reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch, do_jump  out  1 each  registered control
- comp_ctrl, reg_wr_src_ctrl, alu_op1_ctrl, alu_op2_ctrl, alu_ctrl, mem_ctrl  out  control_types enums  registered control
- ctrl_valid_o  out  1  registered bundle is a live instruction
- stall_o  out  1  upstream must hold PC/IF-ID
- trap_o  out  1  trap pending
- trap_cause_o  out  2  01 ECALL, 10 EBREAK, 00 none
- fault_o  out  1  sticky memory timeout fault

Behaviour:
- Reset (rst=1 at posedge), FSM and outputs:
  - FSM=RUN, counter=0.
  - All control outputs take the NOP defaults: write/read/branch/jump=0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_REG2, ALU_NOP, MEM_NOP.
  - ctrl_valid_o=0, stall_o=0, trap_o=0, trap_cause_o=00, fault_o=0.
  - Reset overrides every other input, in every state, including mid-wait.
- stall_o is a Moore output: 1 iff state is MEM_WAIT, TRAP or FAULT.
- Capture latency: 1 cycle. Control outputs change only at posedge.
- RUN state:
  - If flush_i: bundle <= NOP, ctrl_valid_o<=0, state stays RUN. Flush beats instr_valid_i.
  - Else if instr_valid_i: bundle <= decode(opcode_in), ctrl_valid_o<=1.
  - Else: bundle <= NOP, ctrl_valid_o<=0.
  - After a valid non-flushed capture:
    - load/store with MEM_WAIT_EN=1: next state MEM_WAIT, counter<=0.
    - ECALL/EBREAK with SYS_TRAP_EN=1: next state TRAP, trap_cause_o set, bundle forced NOP, ctrl_valid_o<=0.
    - anything else: stay RUN.
- MEM_WAIT state:
  - Bundle and ctrl_valid_o held; flush_i ignored (the memory op is committed).
  - mem_ack_i=1: next state RUN and bundle <= NOP, ctrl_valid_o<=0 (no new capture that edge, since stall_o was 1).
  - Else if counter==TIMEOUT-1: next state FAULT.
  - Else: counter+1. Counter width is $clog2(TIMEOUT+1).
  - mem_ack_i on the same edge as the timeout: ack wins, go to RUN.
- TRAP state:
  - trap_o=1, bundle NOP, flush_i and instr_valid_i ignored.
  - trap_ack_i: next state RUN, trap_o<=0, trap_cause_o<=00.
- FAULT state:
  - fault_o=1, ctrl_valid_o=0, bundle NOP.
  - Terminal until rst; all inputs ignored.
- mem_ack_i outside MEM_WAIT and trap_ack_i outside TRAP are ignored.
- FSM encoding is RUN/MEM_WAIT/TRAP/FAULT. Any illegal state returns to RUN with outputs at NOP on the next edge.

Test Plan:
- ADD then XORI back-to-back with instr_valid_i=1 -> cycle+1 alu_ctrl=ALU_ADD, alu_op2_ctrl=SRC2_REG2; cycle+2 ALU_XOR, SRC2_IMM; ctrl_valid_o=1 both, stall_o=0.
- LW, mem_ack_i asserted 3 cycles after capture -> mem_ctrl=MEM_LW, mem_do_read_ctrl=1 held for 3 stall cycles; cycle+4 stall_o=0, ctrl_valid_o=0, following instruction captured cycle+5.
- SW with TIMEOUT=4, no ack -> stall_o=1 for 4 cycles, then fault_o=1 sticky; rst for one cycle -> all outputs back to NOP, fault_o=0.
- BEQ with flush_i=1 in the same cycle -> ctrl_valid_o=0, do_branch=0, comp_ctrl=BR_NOP; flush during MEM_WAIT -> no effect on the held LW bundle.
- ECALL (SYS_TRAP_EN=1) -> trap_o=1, trap_cause_o=01, stall_o=1 until trap_ack_i, then RUN; with SYS_TRAP_EN=0 -> no trap, ctrl_valid_o=1 with NOP bundle.
- MEM_WAIT_EN=0, LH -> mem_ctrl=MEM_LH captured, stall_o never asserts; rst asserted mid-MEM_WAIT (MEM_WAIT_EN=1) -> RUN and NOP next edge.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// Shared RV32I decode/control encodings and the ID/EX sequencer interface.
// master: upstream driver of instruction, flush and memory/trap acks.
// slave: the sequencer, returning the registered control bundle and status.
package control_types;

  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } opcode_out_t;

  typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_ctrl_t;
  typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PCPLUS4} reg_wr_src_t;
  typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} alu_op1_t;
  typedef enum logic {SRC2_REG2, SRC2_IMM} alu_op2_t;
  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_t;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_ctrl_t;

endpackage

interface ctrl_sequencer_if;
  logic                      instr_valid_i;
  control_types::opcode_out_t opcode_in;
  logic                      flush_i;
  logic                      mem_ack_i;
  logic                      trap_ack_i;

  logic                      reg_do_write_ctrl;
  logic                      mem_do_write_ctrl;
  logic                      mem_do_read_ctrl;
  logic                      do_branch;
  logic                      do_jump;
  control_types::comp_ctrl_t  comp_ctrl;
  control_types::reg_wr_src_t reg_wr_src_ctrl;
  control_types::alu_op1_t    alu_op1_ctrl;
  control_types::alu_op2_t    alu_op2_ctrl;
  control_types::alu_ctrl_t   alu_ctrl;
  control_types::mem_ctrl_t   mem_ctrl;
  logic                      ctrl_valid_o;
  logic                      stall_o;
  logic                      trap_o;
  logic [1:0]                trap_cause_o;
  logic                      fault_o;

  modport master (
    output instr_valid_i, opcode_in, flush_i, mem_ack_i, trap_ack_i,
    input  reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch, do_jump,
           comp_ctrl, reg_wr_src_ctrl, alu_op1_ctrl, alu_op2_ctrl, alu_ctrl, mem_ctrl,
           ctrl_valid_o, stall_o, trap_o, trap_cause_o, fault_o
  );

  modport slave (
    input  instr_valid_i, opcode_in, flush_i, mem_ack_i, trap_ack_i,
    output reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl, do_branch, do_jump,
           comp_ctrl, reg_wr_src_ctrl, alu_op1_ctrl, alu_op2_ctrl, alu_ctrl, mem_ctrl,
           ctrl_valid_o, stall_o, trap_o, trap_cause_o, fault_o
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Registered RV32I control decoder at ID/EX with a RUN/MEM_WAIT/TRAP/FAULT sequencer.
// Latency: one cycle from opcode_in to the registered bundle.
// Backpressure: stall_o (registered, high in MEM_WAIT/TRAP/FAULT) holds PC and IF/ID upstream.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries instruction in, control bundle and status out.
module ctrl_sequencer
  import control_types::*;
#(
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          SYS_TRAP_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  ctrl_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic        reg_do_write;
    logic        mem_do_write;
    logic        mem_do_read;
    logic        do_branch;
    logic        do_jump;
    comp_ctrl_t  comp;
    reg_wr_src_t wr_src;
    alu_op1_t    op1;
    alu_op2_t    op2;
    alu_ctrl_t   alu;
    mem_ctrl_t   mem;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    reg_do_write: 1'b0, mem_do_write: 1'b0, mem_do_read: 1'b0, do_branch: 1'b0, do_jump: 1'b0,
    comp: BR_NOP, wr_src: WRSRC_ALURES, op1: SRC1_REG1, op2: SRC2_REG2, alu: ALU_NOP, mem: MEM_NOP
  };

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_TRAP, S_FAULT} state_t;

  function automatic ctrl_bundle_t decode(opcode_out_t op);
    ctrl_bundle_t b;
    b = CTRL_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
        b.reg_do_write = 1'b1;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: begin
        b.reg_do_write = 1'b1; b.op2 = SRC2_IMM;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        b.reg_do_write = 1'b1; b.mem_do_read = 1'b1; b.op2 = SRC2_IMM; b.wr_src = WRSRC_MEMREAD;
      end
      OP_SB, OP_SH, OP_SW: begin
        b.mem_do_write = 1'b1; b.op2 = SRC2_IMM;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        // ALU forms the branch target (PC + imm); the comparator decides taken.
        b.do_branch = 1'b1; b.op1 = SRC1_PC; b.op2 = SRC2_IMM;
      end
      OP_JAL: begin
        b.reg_do_write = 1'b1; b.do_jump = 1'b1; b.op1 = SRC1_PC; b.op2 = SRC2_IMM; b.wr_src = WRSRC_PCPLUS4;
      end
      OP_JALR: begin
        b.reg_do_write = 1'b1; b.do_jump = 1'b1; b.op2 = SRC2_IMM; b.wr_src = WRSRC_PCPLUS4;
      end
      OP_LUI:   begin b.reg_do_write = 1'b1; b.op1 = SRC1_ZERO; b.op2 = SRC2_IMM; end
      OP_AUIPC: begin b.reg_do_write = 1'b1; b.op1 = SRC1_PC;   b.op2 = SRC2_IMM; end
      default: ;
    endcase
    case (op)
      OP_SUB:           b.alu = ALU_SUB;
      OP_SLL, OP_SLLI:  b.alu = ALU_SLL;
      OP_SLT, OP_SLTI:  b.alu = ALU_SLT;
      OP_SLTU, OP_SLTIU: b.alu = ALU_SLTU;
      OP_XOR, OP_XORI:  b.alu = ALU_XOR;
      OP_SRL, OP_SRLI:  b.alu = ALU_SRL;
      OP_SRA, OP_SRAI:  b.alu = ALU_SRA;
      OP_OR, OP_ORI:    b.alu = ALU_OR;
      OP_AND, OP_ANDI:  b.alu = ALU_AND;
      OP_ADD, OP_ADDI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
        b.alu = ALU_ADD;
      default:          b.alu = ALU_NOP;
    endcase
    case (op)
      OP_BEQ:  b.comp = BR_EQ;
      OP_BNE:  b.comp = BR_NE;
      OP_BLT:  b.comp = BR_LT;
      OP_BGE:  b.comp = BR_GE;
      OP_BLTU: b.comp = BR_LTU;
      OP_BGEU: b.comp = BR_GEU;
      default: b.comp = BR_NOP;
    endcase
    case (op)
      OP_LB:   b.mem = MEM_LB;
      OP_LH:   b.mem = MEM_LH;
      OP_LW:   b.mem = MEM_LW;
      OP_LBU:  b.mem = MEM_LBU;
      OP_LHU:  b.mem = MEM_LHU;
      OP_SB:   b.mem = MEM_SB;
      OP_SH:   b.mem = MEM_SH;
      OP_SW:   b.mem = MEM_SW;
      default: b.mem = MEM_NOP;
    endcase
    return b;
  endfunction

  state_t       state;
  logic [CW-1:0] wait_cnt;
  ctrl_bundle_t bundle;
  logic         valid_q, stall_q, trap_q, fault_q;
  logic [1:0]   cause_q;

  ctrl_bundle_t dec;
  logic         is_mem, is_sys;

  always_comb begin
    dec    = decode(bus.opcode_in);
    is_mem = dec.mem_do_read | dec.mem_do_write;
    is_sys = (bus.opcode_in == OP_ECALL) || (bus.opcode_in == OP_EBREAK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      bundle   <= CTRL_NOP;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          wait_cnt <= '0;
          if (bus.flush_i || !bus.instr_valid_i) begin
            bundle  <= CTRL_NOP;
            valid_q <= 1'b0;
          end else if (SYS_TRAP_EN && is_sys) begin
            // The trapping instruction itself never reaches EX.
            state   <= S_TRAP;
            bundle  <= CTRL_NOP;
            valid_q <= 1'b0;
            stall_q <= 1'b1;
            trap_q  <= 1'b1;
            cause_q <= (bus.opcode_in == OP_ECALL) ? 2'b01 : 2'b10;
          end else begin
            bundle  <= dec;
            valid_q <= 1'b1;
            if (MEM_WAIT_EN && is_mem) begin
              state   <= S_MEM_WAIT;
              stall_q <= 1'b1;
            end
          end
        end
        S_MEM_WAIT: begin
          // Ack is checked first so an ack on the last allowed cycle still completes.
          if (bus.mem_ack_i) begin
            state   <= S_RUN;
            bundle  <= CTRL_NOP;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            state   <= S_FAULT;
            bundle  <= CTRL_NOP;
            valid_q <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_TRAP: begin
          if (bus.trap_ack_i) begin
            state   <= S_RUN;
            stall_q <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
          bundle   <= CTRL_NOP;
          valid_q  <= 1'b0;
          stall_q  <= 1'b0;
          trap_q   <= 1'b0;
          cause_q  <= 2'b00;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_do_write_ctrl = bundle.reg_do_write;
  assign bus.mem_do_write_ctrl = bundle.mem_do_write;
  assign bus.mem_do_read_ctrl  = bundle.mem_do_read;
  assign bus.do_branch         = bundle.do_branch;
  assign bus.do_jump           = bundle.do_jump;
  assign bus.comp_ctrl         = bundle.comp;
  assign bus.reg_wr_src_ctrl   = bundle.wr_src;
  assign bus.alu_op1_ctrl      = bundle.op1;
  assign bus.alu_op2_ctrl      = bundle.op2;
  assign bus.alu_ctrl          = bundle.alu;
  assign bus.mem_ctrl          = bundle.mem;
  assign bus.ctrl_valid_o      = valid_q;
  assign bus.stall_o           = stall_q;
  assign bus.trap_o            = trap_q;
  assign bus.trap_cause_o      = cause_q;
  assign bus.fault_o           = fault_q;

endmodule
